// File: rtl/led_spinner_if.sv
// led_spinner_if -- control/pattern bundle for the LED spinner.
//   tick_i  : single-cycle step strobe (from a prescaler)
//   en_i    : 1 = advance on tick, 0 = freeze
//   dir_i   : 0 = upward / low-side fill, 1 = downward / high-side fill
//   mode_i  : 00 rotate, 01 bounce, 10 fill, 11 inverted rotate
//   led_o   : LED pattern (NUM_LEDS bits)
//   wrap_o  : one-cycle pulse on pattern wrap or bounce reversal
// master = controller side, slave = spinner side.
interface led_spinner_if #(
    parameter int NUM_LEDS = 8
);
    logic                tick_i;
    logic                en_i;
    logic                dir_i;
    logic [1:0]          mode_i;
    logic [NUM_LEDS-1:0] led_o;
    logic                wrap_o;

    modport master (
        output tick_i, en_i, dir_i, mode_i,
        input  led_o, wrap_o
    );

    modport slave (
        input  tick_i, en_i, dir_i, mode_i,
        output led_o, wrap_o
    );
endinterface

// File: rtl/led_spinner.sv
// led_spinner -- LED pattern generator (rotate / bounce / fill / inverted).
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : led_spinner_if.slave (tick_i, en_i, dir_i, mode_i in;
//            led_o, wrap_o out)
// State is mode_q, a step counter cnt_q, a bounce direction bdir_q and the
// registered wrap pulse. led_o is decoded per LED from registered state and
// dir_i only, so tick/enable/mode never reach the LEDs combinationally.

// Per-LED decode: one instance per output bit.
module led_spinner_lane #(
    parameter int NUM_LEDS = 8,
    parameter int IDX      = 0,
    parameter int CW       = 4
) (
    input  logic [1:0]    mode,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] k,
    input  logic          dir,
    output logic          led
);
    // POS is this LED's index from the bottom, MIR its index from the top;
    // a fill of k lights the k lowest (or highest) LEDs.
    localparam logic [CW-1:0] POS = CW'(IDX);
    localparam logic [CW-1:0] MIR = CW'(NUM_LEDS - 1 - IDX);

    logic hit;
    logic fill_on;

    assign hit     = (cnt == POS);
    assign fill_on = dir ? (MIR < k) : (POS < k);

    always_comb begin
        led = hit;
        case (mode)
            2'b00, 2'b01: led = hit;
            2'b10:        led = fill_on;
            default:      led = ~hit;
        endcase
    end
endmodule

module led_spinner #(
    parameter int NUM_LEDS = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    led_spinner_if.slave  bus
);
    // Counter spans 0..2N-1 so fill can count up and back down.
    localparam int CW = $clog2(2 * NUM_LEDS);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] N_LEDS    = CW'(NUM_LEDS);
    localparam logic [CW-1:0] LAST      = CW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LAST_M1   = CW'(NUM_LEDS - 2);
    localparam logic [CW-1:0] FILL_LAST = CW'(2 * NUM_LEDS - 1);

    typedef enum logic [1:0] {
        M_ROT  = 2'b00,
        M_BNC  = 2'b01,
        M_FILL = 2'b10,
        M_INV  = 2'b11
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bdir_q, bdir_d;
    logic                wrap_q, wrap_d;
    logic [CW-1:0]       k;
    logic [NUM_LEDS-1:0] led;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= M_ROT;
            cnt_q  <= '0;
            bdir_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            bdir_q <= bdir_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        bdir_d = bdir_q;
        wrap_d = 1'b0;
        if (bus.mode_i != mode_q) begin
            // Mode switch restarts the pattern; a tick on this cycle is lost.
            mode_d = mode_e'(bus.mode_i);
            cnt_d  = '0;
            bdir_d = 1'b0;
        end else if (bus.tick_i && bus.en_i) begin
            case (mode_q)
                M_ROT, M_INV: begin
                    if (!bus.dir_i) begin
                        wrap_d = (cnt_q == LAST);
                        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + ONE;
                    end else begin
                        wrap_d = (cnt_q == '0);
                        cnt_d  = (cnt_q == '0) ? LAST : cnt_q - ONE;
                    end
                end
                M_BNC: begin
                    // Reversal steps away from the end immediately, so the
                    // end LED is lit for a single step only.
                    if (!bdir_q) begin
                        if (cnt_q == LAST) begin
                            cnt_d  = LAST_M1;
                            bdir_d = 1'b1;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + ONE;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d  = ONE;
                            bdir_d = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d  = cnt_q - ONE;
                        end
                    end
                end
                default: begin
                    wrap_d = (cnt_q == FILL_LAST);
                    cnt_d  = (cnt_q == FILL_LAST) ? '0 : cnt_q + ONE;
                end
            endcase
        end
    end

    // Fill length: grows 1..N over the first half, shrinks N-1..0 after.
    assign k = (cnt_q < N_LEDS) ? (cnt_q + ONE) : (FILL_LAST - cnt_q);

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
        led_spinner_lane #(
            .NUM_LEDS (NUM_LEDS),
            .IDX      (i),
            .CW       (CW)
        ) u_lane (
            .mode (mode_q),
            .cnt  (cnt_q),
            .k    (k),
            .dir  (bus.dir_i),
            .led  (led[i])
        );
    end

    assign bus.led_o  = led;
    assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_led_spinner.sv
module tb_led_spinner;
    localparam int N = 8;

    typedef struct packed {
        int   cnt;
        logic up;
        logic wrap;
    } mst_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    led_spinner_if #(.NUM_LEDS(N)) bus ();

    led_spinner #(.NUM_LEDS(N)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    int   m_mode = 0;
    int   m_cnt  = 0;
    logic m_up   = 1'b1;
    logic m_wrap = 1'b0;

    function automatic mst_t model_step(int mode, int cnt, logic up, logic dir);
        mst_t s;
        s.cnt  = cnt;
        s.up   = up;
        s.wrap = 1'b0;
        case (mode)
            0, 3: begin
                if (!dir) begin s.cnt = (cnt + 1) % N;     s.wrap = (cnt == N - 1); end
                else      begin s.cnt = (cnt + N - 1) % N; s.wrap = (cnt == 0);     end
            end
            1: begin
                if (up) begin
                    if (cnt == N - 1) begin s.cnt = N - 2; s.up = 1'b0; s.wrap = 1'b1; end
                    else s.cnt = cnt + 1;
                end else begin
                    if (cnt == 0) begin s.cnt = 1; s.up = 1'b1; s.wrap = 1'b1; end
                    else s.cnt = cnt - 1;
                end
            end
            default: begin s.cnt = (cnt + 1) % (2 * N); s.wrap = (cnt == 2 * N - 1); end
        endcase
        return s;
    endfunction

    function automatic logic [63:0] exp_led(int mode, int cnt, logic dir);
        logic [63:0] one, mask, low;
        int k;
        one  = 64'd1 << cnt;
        mask = (64'd1 << N) - 64'd1;
        case (mode)
            0, 1:    return one;
            3:       return ~one & mask;
            default: begin
                k   = (cnt < N) ? cnt + 1 : 2 * N - 1 - cnt;
                low = (64'd1 << k) - 64'd1;
                return dir ? (low << (N - k)) : low;
            end
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_mode <= 0; m_cnt <= 0; m_up <= 1'b1; m_wrap <= 1'b0;
        end else if (int'(bus.mode_i) != m_mode) begin
            m_mode <= int'(bus.mode_i); m_cnt <= 0; m_up <= 1'b1; m_wrap <= 1'b0;
        end else if (bus.tick_i && bus.en_i) begin
            m_cnt  <= model_step(m_mode, m_cnt, m_up, bus.dir_i).cnt;
            m_up   <= model_step(m_mode, m_cnt, m_up, bus.dir_i).up;
            m_wrap <= model_step(m_mode, m_cnt, m_up, bus.dir_i).wrap;
        end else begin
            m_wrap <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare on every falling edge (inputs are stable then).
    always @(negedge clk_i) begin
        chk("model_led", 64'(bus.led_o), exp_led(m_mode, m_cnt, bus.dir_i));
        chk("model_wrap", 64'(bus.wrap_o), 64'(m_wrap));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic tick();
        bus.tick_i = 1'b1;
        cyc();
        bus.tick_i = 1'b0;
    endtask

    int bexp [16] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
    logic [7:0] fexp [16] = '{8'h03,8'h07,8'h0F,8'h1F,8'h3F,8'h7F,8'hFF,8'h7F,
                              8'h3F,8'h1F,8'h0F,8'h07,8'h03,8'h01,8'h00,8'h01};
    int wraps;

    initial begin
        bus.tick_i = 1'b0; bus.en_i = 1'b1; bus.dir_i = 1'b0; bus.mode_i = 2'b00;
        cyc(); cyc();
        chk("reset_led", 64'(bus.led_o), 64'h01);
        chk("reset_wrap", 64'(bus.wrap_o), 64'h0);
        rst_ni = 1'b1;
        cyc();

        // Rotate up: 02,04,...,80,01 with wrap after the 8th tick.
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rot_led", 64'(bus.led_o), 64'd1 << (i % 8));
            chk("rot_wrap", 64'(bus.wrap_o), 64'(i == 8));
        end
        cyc();
        chk("rot_wrap_clear", 64'(bus.wrap_o), 64'h0);

        // Bounce, dir_i toggling must not matter.
        bus.mode_i = 2'b01;
        cyc();
        chk("bnc_start", 64'(bus.led_o), 64'h01);
        wraps = 0;
        for (int i = 1; i <= 16; i++) begin
            bus.dir_i = i[0];
            tick();
            chk("bnc_led", 64'(bus.led_o), 64'd1 << bexp[i-1]);
            if (bus.wrap_o) wraps++;
        end
        chk("bnc_wrap_count", 64'(wraps), 64'd2);

        // Fill, low side then high side.
        bus.dir_i  = 1'b0;
        bus.mode_i = 2'b10;
        cyc();
        chk("fill_start", 64'(bus.led_o), 64'h01);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("fill_led", 64'(bus.led_o), 64'(fexp[i-1]));
            chk("fill_wrap", 64'(bus.wrap_o), 64'(i == 16));
        end
        bus.dir_i = 1'b1;
        #1;
        chk("fill_hi0", 64'(bus.led_o), 64'h80);
        tick();
        chk("fill_hi1", 64'(bus.led_o), 64'hC0);
        tick(); tick();
        chk("fill_hi3", 64'(bus.led_o), 64'hF0);

        // Asynchronous reset mid-fill, then restart into fill from reset.
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_led", 64'(bus.led_o), 64'h01);
        chk("async_rst_wrap", 64'(bus.wrap_o), 64'h0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("rst_exit_load", 64'(bus.led_o), 64'h80);

        // Inverted rotate downward from reset.
        rst_ni = 1'b0;
        bus.mode_i = 2'b11;
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("inv_start", 64'(bus.led_o), 64'hFE);
        tick();
        chk("inv_led", 64'(bus.led_o), 64'h7F);
        chk("inv_wrap", 64'(bus.wrap_o), 64'h1);
        bus.en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_led", 64'(bus.led_o), 64'h7F);
            chk("frozen_wrap", 64'(bus.wrap_o), 64'h0);
        end
        bus.en_i = 1'b1;

        // Mode change coincident with a tick: tick dropped.
        bus.mode_i = 2'b00;
        cyc();
        tick(); tick();
        chk("rot_dn", 64'(bus.led_o), 64'h40);
        bus.mode_i = 2'b01;
        tick();
        chk("chg_tick_led", 64'(bus.led_o), 64'h01);
        chk("chg_tick_wrap", 64'(bus.wrap_o), 64'h0);
        cyc();
        chk("chg_tick_hold", 64'(bus.led_o), 64'h01);

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
